// File: rtl/shapool_result_tx_if.sv
// Byte-wide valid/ready link from the result framer to the host-link serializer.
interface shapool_result_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/shapool_result_tx.sv
// Captures the shapool winning nonce on a success rising edge and returns it to
// the host as a 7-byte frame: SOF, id, nonce MSB..LSB, XOR checksum.
module shapool_result_tx #(
  parameter logic [7:0] SOF       = 8'hA5,
  parameter int         FRAME_LEN = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        success,
  input  logic [31:0]                 nonce,
  input  logic [7:0]                  nonce_start_MSB,
  input  logic                        clear,
  output logic                        busy,
  output logic                        halt,
  output logic                        dropped,
  shapool_result_tx_if.master         tx
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  id_q;
  logic [31:0] nonce_q;
  logic [7:0]  chk_q;
  logic        success_q;
  logic        dropped_q, dropped_d;
  logic        load;
  logic        rise;
  logic [7:0]  byte_sel;

  assign rise = success && !success_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      success_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      success_q <= success;
      dropped_q <= dropped_d;
    end
  end

  // Frame payload is frozen at capture so live pool activity cannot corrupt it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_q    <= 8'h00;
      nonce_q <= 32'h0;
      chk_q   <= 8'h00;
    end else if (load) begin
      id_q    <= nonce_start_MSB;
      nonce_q <= nonce;
      chk_q   <= nonce_start_MSB ^ nonce[31:24] ^ nonce[23:16] ^ nonce[15:8] ^ nonce[7:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dropped_d   = dropped_q;
    load        = 1'b0;
    tx.tx_valid = 1'b0;
    busy        = 1'b0;
    halt        = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          load    = 1'b1;
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx.tx_valid = 1'b1;
        busy        = 1'b1;
        halt        = 1'b1;
        if (rise) dropped_d = 1'b1;
        if (tx.tx_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 3'd0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      DONE: begin
        halt = 1'b1;
        if (rise) dropped_d = 1'b1;
        if (clear) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (idx_q)
      3'd0:    byte_sel = SOF;
      3'd1:    byte_sel = id_q;
      3'd2:    byte_sel = nonce_q[31:24];
      3'd3:    byte_sel = nonce_q[23:16];
      3'd4:    byte_sel = nonce_q[15:8];
      3'd5:    byte_sel = nonce_q[7:0];
      default: byte_sel = chk_q;
    endcase
  end

  assign tx.tx_data = (state_q == SEND) ? byte_sel : 8'h00;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_shapool_result_tx.sv
// Table-driven bench for shapool_result_tx with a byte scoreboard on the tx link.
module tb_shapool_result_tx;

  logic        clk;
  logic        reset;
  logic        success;
  logic [31:0] nonce;
  logic [7:0]  nonceStartMsb;
  logic        clear;
  logic        busy;
  logic        halt;
  logic        dropped;

  shapool_result_tx_if txIf ();

  shapool_result_tx dut (
    .clk             (clk),
    .reset           (reset),
    .success         (success),
    .nonce           (nonce),
    .nonce_start_MSB (nonceStartMsb),
    .clear           (clear),
    .busy            (busy),
    .halt            (halt),
    .dropped         (dropped),
    .tx              (txIf.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] nonce;
    logic [3:0]  readyPat;
    logic [7:0]  chk;
    int          clearAt;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] expQ[$];
  int         checks = 0;
  int         errors = 0;
  logic       stallPending = 1'b0;
  logic [7:0] heldData = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushFrame(input logic [7:0] id, input logic [31:0] n, input logic [7:0] chk);
    expQ.push_back(8'hA5);
    expQ.push_back(id);
    expQ.push_back(n[31:24]);
    expQ.push_back(n[23:16]);
    expQ.push_back(n[15:8]);
    expQ.push_back(n[7:0]);
    expQ.push_back(chk);
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle ahead of the capturing edge.
  always @(negedge clk) begin
    if (!reset) begin
      stallPending = 1'b0;
    end else if (txIf.tx_valid) begin
      if (stallPending) checkOutput("stall stable", txIf.tx_data, heldData);
      if (txIf.tx_ready) begin
        stallPending = 1'b0;
        if (expQ.size() == 0) checkOutput("unexpected byte", txIf.tx_data, 32'hFFFF_FFFF);
        else checkOutput("frame byte", txIf.tx_data, expQ.pop_front());
      end else begin
        stallPending = 1'b1;
        heldData     = txIf.tx_data;
      end
    end else begin
      stallPending = 1'b0;
    end
  end

  task automatic waitDone(input string name, input logic [3:0] pat, input int clearAt);
    bit done = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      txIf.tx_ready = pat[cyc % 4];
      clear         = (cyc == clearAt);
      if (cyc == 1) nonce = ~nonce;
      stepCycle();
      clear = 1'b0;
      if (halt && !busy) begin
        done = 1'b1;
        break;
      end
    end
    txIf.tx_ready = 1'b0;
    checkOutput({name, " reached DONE"}, 32'(done), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    success = 1'b0;
    stepCycle();
    nonceStartMsb = v.id;
    nonce         = v.nonce;
    pushFrame(v.id, v.nonce, v.chk);
    success = 1'b1;
    stepCycle();
    checkOutput("first byte valid", 32'(txIf.tx_valid), 32'd1);
    checkOutput("first byte SOF", 32'(txIf.tx_data), 32'hA5);
    checkOutput("busy in SEND", 32'(busy), 32'd1);
    waitDone("frame", v.readyPat, v.clearAt);
    checkOutput("DONE valid low", 32'(txIf.tx_valid), 32'd0);
    checkOutput("DONE halt", 32'(halt), 32'd1);
    checkOutput("bytes left", 32'(expQ.size()), 32'd0);
    checkOutput("no drop", 32'(dropped), 32'd0);
    clear = 1'b1;
    stepCycle();
    clear = 1'b0;
    checkOutput("halt after clear", 32'(halt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("no rearm while high", 32'(txIf.tx_valid), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{id: 8'h00, nonce: 32'h1234ABCD, readyPat: 4'b1111, chk: 8'h40, clearAt: -1};
    vecs[1] = '{id: 8'h03, nonce: 32'hFFFFFFFF, readyPat: 4'b1001, chk: 8'h03, clearAt: -1};
    vecs[2] = '{id: 8'h5A, nonce: 32'h00000001, readyPat: 4'b1101, chk: 8'h5B, clearAt: 2};
    vecs[3] = '{id: 8'hC3, nonce: 32'hDEADBEEF, readyPat: 4'b0110, chk: 8'hE1, clearAt: 1};

    reset         = 1'b0;
    success       = 1'b0;
    nonce         = 32'h0;
    nonceStartMsb = 8'h00;
    clear         = 1'b0;
    txIf.tx_ready = 1'b0;
    #12;
    checkOutput("reset valid", 32'(txIf.tx_valid), 32'd0);
    checkOutput("reset data", 32'(txIf.tx_data), 32'h00);
    checkOutput("reset halt", 32'(halt), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset dropped", 32'(dropped), 32'd0);
    reset = 1'b1;
    stepCycle();

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    // Rise during SEND, then clear and rise together in DONE.
    success = 1'b0;
    stepCycle();
    nonceStartMsb = 8'h77;
    nonce         = 32'h000000FF;
    pushFrame(8'h77, 32'h000000FF, 8'h88);
    success = 1'b1;
    stepCycle();
    txIf.tx_ready = 1'b1;
    stepCycle();
    success = 1'b0;
    stepCycle();
    success = 1'b1;
    stepCycle();
    checkOutput("dropped on SEND rise", 32'(dropped), 32'd1);
    waitDone("dropped frame", 4'b1111, -1);
    checkOutput("dropped bytes left", 32'(expQ.size()), 32'd0);
    success = 1'b0;
    stepCycle();
    success = 1'b1;
    clear   = 1'b1;
    stepCycle();
    clear = 1'b0;
    checkOutput("clear wins halt", 32'(halt), 32'd0);
    checkOutput("dropped sticky", 32'(dropped), 32'd1);
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("no extra frame", 32'(txIf.tx_valid), 32'd0);
    end

    // Asynchronous reset after three bytes have been accepted.
    success = 1'b0;
    stepCycle();
    nonceStartMsb = 8'h11;
    nonce         = 32'hCAFEF00D;
    pushFrame(8'h11, 32'hCAFEF00D, 8'h11 ^ 8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D);
    success       = 1'b1;
    txIf.tx_ready = 1'b1;
    stepCycle();
    for (int i = 0; i < 3; i++) stepCycle();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async valid", 32'(txIf.tx_valid), 32'd0);
    checkOutput("async data", 32'(txIf.tx_data), 32'h00);
    checkOutput("async halt", 32'(halt), 32'd0);
    checkOutput("async busy", 32'(busy), 32'd0);
    checkOutput("async dropped", 32'(dropped), 32'd0);
    checkOutput("aborted bytes", 32'(expQ.size()), 32'd4);
    expQ.delete();
    txIf.tx_ready = 1'b0;
    success       = 1'b0;
    stepCycle();
    reset = 1'b1;
    stepCycle();
    applyStimulus(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
